// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
//   Shared types and defaults for the PLL reset sequencer.
//   - pll_state_e : sequencer states
//   - seq_outs_t  : the registered Moore outputs as one bundle
//   - Def*        : default cycle counts for a 50 MHz reference clock
//   - decode_outputs() : Moore output decode for a given state
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      StPllRst   = 3'd0,
      StWaitLock = 3'd1,
      StStable   = 3'd2,
      StRun      = 3'd3,
      StFault    = 3'd4
   } pll_state_e;

   localparam int unsigned DefPllRstCycles     = 16;
   localparam int unsigned DefLockStableCycles = 1024;
   localparam int unsigned DefLockTimeoutCycles = 50000;
   localparam int unsigned DefMaxRetries       = 3;
   localparam int unsigned DefCntW             = 16;

   typedef struct packed {
      logic pll_rst;
      logic sys_rst;
      logic ready;
      logic fault;
   } seq_outs_t;

   localparam seq_outs_t ResetOuts = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};

   function automatic seq_outs_t decode_outputs(input pll_state_e st);
      seq_outs_t o;
      o = ResetOuts;
      unique case (st)
         StPllRst:   o = ResetOuts;
         StWaitLock: o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
         StStable:   o = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};
         StRun:      o = '{pll_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1, fault: 1'b0};
         StFault:    o = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b1};
         default:    o = ResetOuts;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level, reset to 0.
//   clk  in  destination clock
//   rst  in  synchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronized output (2 cycles latency)
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Power-up sequencer for the system PLL, in the reference-clock domain. Holds the PLL in
//   reset, waits for lock, requires lock to stay stable, then releases the system reset
//   request. Lock loss in RUN triggers a relock; repeated lock timeouts latch a fault.
//   refclk      in   reference clock (only clock)
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock, asynchronous to refclk
//   relock_req  in   single-cycle pulse forcing a new PLL reset sequence
//   pll_rst     out  PLL reset
//   sys_rst     out  active-high system reset request
//   ready       out  clocks locked and stable
//   fault       out  retries exhausted
//   retry_cnt   out  failed lock attempts since last success or clear
//   loss_cnt    out  lock-loss events seen in RUN, saturating
module pll_reset_sequencer
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES      = DefPllRstCycles,
   parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
   parameter int unsigned MAX_RETRIES         = DefMaxRetries,
   parameter int unsigned CNT_W               = DefCntW
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fault,
   output logic [7:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       MaxRetries  = 8'(MAX_RETRIES);

   logic             lk_s;
   pll_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   seq_outs_t        outs_q;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk_s)
   );

   // Next-state, retry and loss counter decode.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      unique case (state_q)
         StPllRst: begin
            if (relock_req) begin
               state_d = StPllRst;
            end else if (cnt_q == RstLast) begin
               state_d = StWaitLock;
            end
         end
         StWaitLock: begin
            if (relock_req) begin
               state_d = StPllRst;
            end else if (lk_s) begin
               state_d = StStable;
            end else if (cnt_q == TimeoutLast) begin
               retry_d = retry_q + 8'd1;
               state_d = (retry_d == MaxRetries) ? StFault : StPllRst;
            end
         end
         StStable: begin
            if (relock_req) begin
               state_d = StPllRst;
            end else if (!lk_s) begin
               // Lock glitch: restart the wait without charging a retry.
               state_d = StWaitLock;
            end else if (cnt_q == StableLast) begin
               state_d = StRun;
               retry_d = 8'd0;
            end
         end
         StRun: begin
            // A simultaneous relock request and lock loss counts as one loss.
            if (relock_req || !lk_s) begin
               state_d = StPllRst;
            end
            if (!lk_s && (loss_q != 8'hFF)) begin
               loss_d = loss_q + 8'd1;
            end
         end
         StFault: begin
            if (relock_req) begin
               state_d = StPllRst;
               retry_d = 8'd0;
            end
         end
         default: begin
            state_d = StPllRst;
         end
      endcase
   end

   // Counter restarts on any state change and on relock_req (which may re-enter PLL_RST
   // from PLL_RST itself); it only runs in the timed states.
   always_comb begin
      cnt_d = '0;
      if ((state_d == state_q) && !relock_req &&
          ((state_q == StPllRst) || (state_q == StWaitLock) || (state_q == StStable))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Outputs are decoded from state_d so they change on the same edge as the state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= StPllRst;
         cnt_q   <= '0;
         retry_q <= 8'd0;
         loss_q  <= 8'd0;
         outs_q  <= ResetOuts;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
         outs_q  <= decode_outputs(state_d);
      end
   end

   assign pll_rst   = outs_q.pll_rst;
   assign sys_rst   = outs_q.sys_rst;
   assign ready     = outs_q.ready;
   assign fault     = outs_q.fault;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with short cycle parameters
//   (PLL_RST=4, STABLE=8, TIMEOUT=20, MAX_RETRIES=2). Edges are counted from the first
//   edge with rst low (edge 1); inputs change and outputs are sampled 1 ns after each edge.
module tb_pll_reset_sequencer;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [7:0] retry_cnt;
   logic [7:0] loss_cnt;

   int checks;
   int errors;
   int ecount;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES      (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (20),
      .MAX_RETRIES         (2),
      .CNT_W               (16)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic tick();
      @(posedge refclk);
      #1;
      ecount++;
   endtask

   // Leaves rst high after two edges so the reset state can be sampled.
   task automatic hold_reset(input logic lock);
      rst        = 1'b1;
      pll_locked = lock;
      relock_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic release_reset();
      rst    = 1'b0;
      ecount = 0;
   endtask

   task automatic tick_to(input int e);
      while (ecount < e) tick();
   endtask

   task automatic test_reset();
      hold_reset(1'b1);
      checks++;
      if ({pll_rst, sys_rst, ready, fault} !== 4'b1100) begin
         errors++;
         $display("FAIL reset_outs got %b want 1100", {pll_rst, sys_rst, ready, fault});
      end
      checks++;
      if ({retry_cnt, loss_cnt} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_cnts got retry=%0d loss=%0d want 0 0", retry_cnt, loss_cnt);
      end
   endtask

   // Lock held from reset: pll_rst falls at edge 4, ready rises at edge 13.
   task automatic test_lock_first();
      logic [3:0] exp;
      hold_reset(1'b1);
      release_reset();
      for (int e = 1; e <= 15; e++) begin
         tick();
         exp = {(e < 4), !(e >= 13), (e >= 13), 1'b0};
         checks++;
         if ({pll_rst, sys_rst, ready, fault} !== exp) begin
            errors++;
            $display("FAIL lock_first edge %0d got %b want %b", e,
                     {pll_rst, sys_rst, ready, fault}, exp);
         end
      end
   endtask

   // No lock: timeouts at edges 24 and 48, second one latches FAULT.
   task automatic test_timeout();
      logic [3:0] exp;
      logic [7:0] exp_retry;
      hold_reset(1'b0);
      release_reset();
      for (int e = 1; e <= 52; e++) begin
         tick();
         exp = {((e < 4) || ((e >= 24) && (e < 28)) || (e >= 48)), 1'b1, 1'b0, (e >= 48)};
         exp_retry = (e >= 48) ? 8'd2 : ((e >= 24) ? 8'd1 : 8'd0);
         checks++;
         if ({pll_rst, sys_rst, ready, fault} !== exp) begin
            errors++;
            $display("FAIL timeout_outs edge %0d got %b want %b", e,
                     {pll_rst, sys_rst, ready, fault}, exp);
         end
         checks++;
         if (retry_cnt !== exp_retry) begin
            errors++;
            $display("FAIL timeout_retry edge %0d got %0d want %0d", e, retry_cnt, exp_retry);
         end
      end
   endtask

   // One-cycle drop after edge 7 (in STABLE) is seen at edge 10; RUN delayed to edge 19.
   task automatic test_glitch();
      logic [3:0] exp;
      hold_reset(1'b1);
      release_reset();
      tick_to(7);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      for (int e = 9; e <= 20; e++) begin
         tick();
         exp = {1'b0, !(e >= 19), (e >= 19), 1'b0};
         checks++;
         if ({pll_rst, sys_rst, ready, fault} !== exp) begin
            errors++;
            $display("FAIL glitch edge %0d got %b want %b", e,
                     {pll_rst, sys_rst, ready, fault}, exp);
         end
      end
      checks++;
      if (retry_cnt !== 8'd0) begin
         errors++;
         $display("FAIL glitch_retry got %0d want 0", retry_cnt);
      end
   endtask

   // Continues from RUN at edge 20: drop after edge 20 -> PLL_RST at 23, RUN again at 36.
   task automatic test_loss();
      logic [3:0] exp;
      pll_locked = 1'b0;
      for (int e = 21; e <= 23; e++) begin
         tick();
         exp = (e < 23) ? 4'b0010 : 4'b1100;
         checks++;
         if ({pll_rst, sys_rst, ready, fault} !== exp) begin
            errors++;
            $display("FAIL loss_drop edge %0d got %b want %b", e,
                     {pll_rst, sys_rst, ready, fault}, exp);
         end
      end
      checks++;
      if (loss_cnt !== 8'd1) begin
         errors++;
         $display("FAIL loss_cnt got %0d want 1", loss_cnt);
      end
      pll_locked = 1'b1;
      for (int e = 24; e <= 37; e++) begin
         tick();
         exp = {(e < 27), !(e >= 36), (e >= 36), 1'b0};
         checks++;
         if ({pll_rst, sys_rst, ready, fault} !== exp) begin
            errors++;
            $display("FAIL loss_relock edge %0d got %b want %b", e,
                     {pll_rst, sys_rst, ready, fault}, exp);
         end
      end
      checks++;
      if (loss_cnt !== 8'd1) begin
         errors++;
         $display("FAIL loss_cnt_hold got %0d want 1", loss_cnt);
      end
   endtask

   task automatic test_relock();
      hold_reset(1'b0);
      release_reset();
      tick_to(50);
      checks++;
      if ({fault, retry_cnt} !== {1'b1, 8'd2}) begin
         errors++;
         $display("FAIL relock_pre_fault got fault=%b retry=%0d want 1 2", fault, retry_cnt);
      end
      // Relock out of FAULT at edge 51.
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      pll_locked = 1'b1;
      checks++;
      if ({pll_rst, sys_rst, ready, fault, retry_cnt} !== {4'b1100, 8'd0}) begin
         errors++;
         $display("FAIL relock_fault got %b retry=%0d want 1100 0",
                  {pll_rst, sys_rst, ready, fault}, retry_cnt);
      end
      tick_to(54);
      checks++;
      if (pll_rst !== 1'b1) begin
         errors++;
         $display("FAIL relock_rst_hold got %b want 1", pll_rst);
      end
      tick();
      checks++;
      if (pll_rst !== 1'b0) begin
         errors++;
         $display("FAIL relock_rst_fall got %b want 0", pll_rst);
      end
      tick_to(63);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL relock_ready_early got %b want 0", ready);
      end
      tick();
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL relock_ready got %b want 1", ready);
      end
      // Plain relock in RUN at edge 67: loss_cnt unchanged.
      tick_to(66);
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      checks++;
      if ({pll_rst, sys_rst, ready, loss_cnt} !== {3'b110, 8'd0}) begin
         errors++;
         $display("FAIL relock_run got %b loss=%0d want 110 0",
                  {pll_rst, sys_rst, ready}, loss_cnt);
      end
      tick_to(80);
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL relock_rerun got %b want 1", ready);
      end
      // Lock drop after edge 82 is seen at 85, together with relock_req.
      tick_to(82);
      pll_locked = 1'b0;
      tick_to(84);
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      pll_locked = 1'b1;
      checks++;
      if ({pll_rst, ready, loss_cnt} !== {2'b10, 8'd1}) begin
         errors++;
         $display("FAIL relock_both got pll_rst=%b ready=%b loss=%0d want 1 0 1",
                  pll_rst, ready, loss_cnt);
      end
      tick_to(88);
      checks++;
      if (loss_cnt !== 8'd1) begin
         errors++;
         $display("FAIL relock_both_hold got %0d want 1", loss_cnt);
      end
   endtask

   task automatic test_rst_abort();
      int budget;
      // Abort in WAIT_LOCK of the second attempt (retry_cnt=1).
      hold_reset(1'b0);
      release_reset();
      tick_to(30);
      checks++;
      if ({pll_rst, retry_cnt} !== {1'b0, 8'd1}) begin
         errors++;
         $display("FAIL abort_wait_pre got pll_rst=%b retry=%0d want 0 1", pll_rst, retry_cnt);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt} !== {4'b1100, 16'h0000}) begin
         errors++;
         $display("FAIL abort_wait got %b retry=%0d loss=%0d want 1100 0 0",
                  {pll_rst, sys_rst, ready, fault}, retry_cnt, loss_cnt);
      end
      // Abort in RUN after one lock loss.
      hold_reset(1'b1);
      release_reset();
      tick_to(14);
      pll_locked = 1'b0;
      tick_to(17);
      pll_locked = 1'b1;
      budget = 0;
      while (ready !== 1'b1 && budget < 40) begin
         tick();
         budget++;
      end
      checks++;
      if ({ready, loss_cnt} !== {1'b1, 8'd1}) begin
         errors++;
         $display("FAIL abort_run_pre got ready=%b loss=%0d want 1 1", ready, loss_cnt);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt} !== {4'b1100, 16'h0000}) begin
         errors++;
         $display("FAIL abort_run got %b retry=%0d loss=%0d want 1100 0 0",
                  {pll_rst, sys_rst, ready, fault}, retry_cnt, loss_cnt);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      ecount     = 0;
      rst        = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      test_reset();
      test_lock_first();
      test_timeout();
      test_glitch();
      test_loss();
      test_relock();
      test_rst_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
